// File: rtl/vga_line_fetch_arbiter.sv
// VGA line fetch arbiter: streams display lines from SDRAM into ping-pong
// line buffers in bursts and interleaves one CPU access between bursts.
module vga_line_fetch_arbiter #(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned MEM_AW     = 26,
  parameter int unsigned LINE_SHIFT = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              vga_mode,
  input  logic              line_req,
  input  logic              line_ab,
  input  logic [15:0]       line_addr,
  output logic              buf_we,
  output logic              buf_sel,
  output logic [9:0]        buf_addr,
  output logic [15:0]       buf_wdata,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic              mem_burst,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [MEM_AW-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned WCW = 11;
  localparam int unsigned BCW = $clog2(BURST_LEN) + 1;
  localparam logic [WCW-1:0] NW_SHORT = WCW'(640);
  localparam logic [WCW-1:0] NW_LONG  = WCW'(1024);

  typedef enum logic [2:0] {
    IDLE,
    VGA_REQ,
    VGA_DATA,
    CPU_REQ,
    CPU_DATA
  } state_t;

  state_t            state;
  logic              req_q;
  logic [MEM_AW-1:0] base;
  logic              sel;
  logic [WCW-1:0]    nwords;
  logic [WCW-1:0]    word_cnt;
  logic [BCW-1:0]    beat_cnt;
  logic              pending;

  logic              line_edge;
  logic [MEM_AW-1:0] new_base;
  logic [MEM_AW-1:0] cur_base;
  logic              cur_sel;
  logic [WCW-1:0]    new_nwords;
  logic [WCW-1:0]    cur_nwords;
  logic [WCW-1:0]    eff_cnt;
  logic [WCW-1:0]    next_cnt;
  logic              burst_last;

  assign new_base = MEM_AW'({line_addr, {LINE_SHIFT{1'b0}}});

  // Line parameters as seen this cycle: a new request edge overrides the latched ones
  always_comb begin
    line_edge  = line_req & ~req_q;
    new_nwords = vga_mode ? NW_LONG : NW_SHORT;
    cur_base   = line_edge ? new_base : base;
    cur_sel    = line_edge ? line_ab : sel;
    cur_nwords = line_edge ? new_nwords : nwords;
    eff_cnt    = line_edge ? '0 : word_cnt;
    // Saturate at the line length so a restart inside a burst drops the surplus words
    next_cnt   = (eff_cnt < cur_nwords) ? eff_cnt + WCW'(1) : eff_cnt;
    burst_last = (beat_cnt == BCW'(BURST_LEN - 1));
  end

  // Request edge latch, arbitration FSM and all registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      base      <= '0;
      sel       <= 1'b0;
      nwords    <= NW_SHORT;
      word_cnt  <= '0;
      beat_cnt  <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      buf_we    <= 1'b0;
      buf_sel   <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_burst <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      req_q   <= line_req;
      buf_we  <= 1'b0;
      cpu_ack <= 1'b0;

      if (line_edge) begin
        base     <= new_base;
        sel      <= line_ab;
        nwords   <= new_nwords;
        word_cnt <= '0;
        pending  <= 1'b1;
        busy     <= 1'b1;
        if (pending) overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            state     <= VGA_REQ;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_burst <= 1'b1;
            mem_addr  <= cur_base + MEM_AW'(eff_cnt);
          end else if (cpu_req) begin
            state     <= CPU_REQ;
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_burst <= 1'b0;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
          end
        end

        VGA_REQ: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_burst <= 1'b0;
            beat_cnt  <= '0;
            state     <= VGA_DATA;
          end else if (line_edge) begin
            mem_addr  <= new_base;
          end
        end

        VGA_DATA: begin
          if (mem_rvalid) begin
            if (eff_cnt < cur_nwords) begin
              buf_we    <= 1'b1;
              buf_sel   <= cur_sel;
              buf_addr  <= eff_cnt[9:0];
              buf_wdata <= mem_rdata;
            end
            word_cnt <= next_cnt;
            beat_cnt <= beat_cnt + BCW'(1);
            if (burst_last) begin
              beat_cnt <= '0;
              if (next_cnt == cur_nwords) begin
                pending <= 1'b0;
                busy    <= 1'b0;
                state   <= IDLE;
              end else if (cpu_req) begin
                state     <= CPU_REQ;
                mem_req   <= 1'b1;
                mem_we    <= cpu_we;
                mem_burst <= 1'b0;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
              end else begin
                state     <= VGA_REQ;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_burst <= 1'b1;
                mem_addr  <= cur_base + MEM_AW'(next_cnt);
              end
            end
          end
        end

        CPU_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mem_we) begin
              cpu_ack <= 1'b1;
              state   <= IDLE;
            end else begin
              state   <= CPU_DATA;
            end
          end
        end

        CPU_DATA: begin
          if (mem_rvalid) begin
            cpu_rdata <= mem_rdata;
            cpu_ack   <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_line_fetch_arbiter.sv
// Directed bench for vga_line_fetch_arbiter with a small SDRAM model.
module tb_vga_line_fetch_arbiter;
  localparam int unsigned AW = 26;
  localparam int unsigned BL = 16;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          vga_mode = 1'b0;
  logic          line_req = 1'b0;
  logic          line_ab = 1'b0;
  logic [15:0]   line_addr = '0;
  logic          buf_we, buf_sel;
  logic [9:0]    buf_addr;
  logic [15:0]   buf_wdata;
  logic          mem_req, mem_we, mem_burst;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [15:0]   cpu_wdata = '0;
  logic [15:0]   cpu_rdata;
  logic          cpu_ack, busy, overrun;

  always #5 clk = ~clk;

  vga_line_fetch_arbiter #(.BURST_LEN(BL), .MEM_AW(AW), .LINE_SHIFT(10)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .vga_mode(vga_mode), .line_req(line_req),
    .line_ab(line_ab), .line_addr(line_addr), .buf_we(buf_we), .buf_sel(buf_sel),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_we(mem_we), .mem_burst(mem_burst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .busy(busy), .overrun(overrun)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: written words, otherwise an address-derived pattern
  logic [15:0] mem_wr [logic [AW-1:0]];

  function automatic logic [15:0] rd(input logic [AW-1:0] a);
    if (mem_wr.exists(a)) return mem_wr[a];
    return a[15:0] ^ {6'h00, a[25:16]} ^ 16'h5A5A;
  endfunction

  // Scoreboard state
  logic [AW-1:0] exp_base = '0;
  logic          exp_sel = 1'b0;
  int            wr_cnt = 0, wr_err = 0, burst_cnt = 0, burst_err = 0;
  int            ack_cnt = 0, cpu_at_burst = -1;
  logic [9:0]    max_addr = '0;
  logic [AW-1:0] last_burst_addr = '0;
  logic          last_acc_burst = 1'b0;

  // SDRAM model: ack on the second request cycle, first read word 3 cycles later
  int            req_cnt = 0, txn_left = 0, txn_delay = 0;
  bit            txn_active = 1'b0;
  logic [AW-1:0] txn_addr = '0;

  always @(negedge clk) begin
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (sys_rst) begin
      txn_active = 1'b0;
      req_cnt    = 0;
    end else if (txn_active) begin
      if (txn_delay > 0) txn_delay--;
      if (txn_delay == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd(txn_addr);
        txn_addr   = txn_addr + AW'(1);
        txn_left--;
        if (txn_left == 0) txn_active = 1'b0;
      end
    end else if (mem_req) begin
      req_cnt++;
      if (req_cnt == 2) begin
        mem_ack        = 1'b1;
        req_cnt        = 0;
        last_acc_burst = mem_burst;
        if (mem_we) begin
          mem_wr[mem_addr] = mem_wdata;
        end else begin
          txn_active = 1'b1;
          txn_delay  = 3;
          txn_addr   = mem_addr;
          txn_left   = mem_burst ? BL : 1;
        end
        if (mem_burst) begin
          if (mem_addr !== exp_base + AW'(BL * burst_cnt)) burst_err++;
          last_burst_addr = mem_addr;
          burst_cnt++;
        end else begin
          cpu_at_burst = burst_cnt;
        end
      end
    end
  end

  // Line buffer write and cpu_ack monitor
  always @(negedge clk) begin
    if (buf_we === 1'b1) begin
      if (buf_addr !== wr_cnt[9:0] || buf_sel !== exp_sel ||
          buf_wdata !== rd(exp_base + AW'(wr_cnt))) wr_err++;
      if (buf_addr > max_addr) max_addr = buf_addr;
      wr_cnt++;
    end
    if (cpu_ack === 1'b1) ack_cnt++;
  end

  task automatic sb_reset(input logic [AW-1:0] b, input logic s);
    exp_base  = b;
    exp_sel   = s;
    wr_cnt    = 0;
    wr_err    = 0;
    burst_cnt = 0;
    burst_err = 0;
    max_addr  = '0;
  endtask

  task automatic start_line(input logic [15:0] la, input logic ab, input logic md, input string tag);
    @(negedge clk); #1;
    sb_reset(AW'({la, 10'b0}), ab);
    line_addr = la;
    line_ab   = ab;
    vga_mode  = md;
    line_req  = 1'b1;
    @(negedge clk); #1;
    check_eq({tag, "_busy_rise"}, busy, 1);
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy === 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    #1;
    check_eq({tag, "_idle_timeout"}, n >= max, 0);
  endtask

  task automatic wait_wr(input int cnt, input string tag, input int max);
    int n = 0;
    while (wr_cnt < cnt && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq({tag, "_wr_timeout"}, n >= max, 0);
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [15:0] d,
                            input string tag, output logic [15:0] rdata);
    int n = 0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    do begin
      @(negedge clk); #1;
      n++;
    end while (cpu_ack !== 1'b1 && n < 200);
    check_eq({tag, "_ack_timeout"}, n >= 200, 0);
    rdata   = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rdv;
    logic        prev;
    int          n;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_buf_we", buf_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    sys_rst = 1'b0;

    // 640-word line 3 into buffer B
    start_line(16'd3, 1'b1, 1'b0, "l3");
    wait_idle("l3", 5000);
    check_eq("l3_writes", wr_cnt, 640);
    check_eq("l3_wr_err", wr_err, 0);
    check_eq("l3_bursts", burst_cnt, 40);
    check_eq("l3_burst_err", burst_err, 0);
    check_eq("l3_last_burst", last_burst_addr, 32'h0000E70);
    check_eq("l3_max_addr", max_addr, 639);
    check_eq("l3_overrun", overrun, 0);

    // 1024-word line at the top of the address space
    start_line(16'hFFFF, 1'b0, 1'b1, "top");
    wait_idle("top", 8000);
    check_eq("top_writes", wr_cnt, 1024);
    check_eq("top_wr_err", wr_err, 0);
    check_eq("top_bursts", burst_cnt, 64);
    check_eq("top_burst_err", burst_err, 0);
    check_eq("top_last_burst", last_burst_addr, 32'h3FFFFF0);
    check_eq("top_max_addr", max_addr, 1023);

    // CPU write during a fetch is served right after the current burst
    start_line(16'd9, 1'b0, 1'b0, "cw");
    wait_wr(20, "cw", 500);
    ack_cnt = 0;
    cpu_access(1'b1, 26'h100, 16'hBEEF, "cw", rdv);
    wait_idle("cw", 5000);
    check_eq("cw_slot", cpu_at_burst, 2);
    check_eq("cw_acks", ack_cnt, 1);
    check_eq("cw_mem", rd(26'h100), 16'hBEEF);
    check_eq("cw_writes", wr_cnt, 640);
    check_eq("cw_wr_err", wr_err, 0);
    check_eq("cw_bursts", burst_cnt, 40);
    check_eq("cw_burst_err", burst_err, 0);

    // CPU read while idle
    @(negedge clk); #1;
    ack_cnt = 0;
    cpu_access(1'b0, 26'h100, 16'h0000, "cr", rdv);
    check_eq("cr_rdata", rdv, 16'hBEEF);
    repeat (4) @(negedge clk);
    #1;
    check_eq("cr_acks", ack_cnt, 1);
    check_eq("cr_burst", last_acc_burst, 0);
    check_eq("cr_busy", busy, 0);

    // Second request edge while the fetch is still running
    start_line(16'd5, 1'b0, 1'b0, "ov");
    n = 0;
    prev = mem_req;
    forever begin
      @(negedge clk); #1;
      n++;
      if ((burst_cnt >= 3 && mem_req === 1'b1 && prev === 1'b0) || n >= 2000) break;
      prev = mem_req;
    end
    check_eq("ov_find_timeout", n >= 2000, 0);
    sb_reset(26'h1C00, 1'b1);
    line_addr = 16'd7;
    line_ab   = 1'b1;
    vga_mode  = 1'b0;
    line_req  = 1'b1;
    @(negedge clk); #1;
    check_eq("ov_flag", overrun, 1);
    @(negedge clk);
    line_req = 1'b0;
    wait_idle("ov", 5000);
    check_eq("ov_writes", wr_cnt, 640);
    check_eq("ov_wr_err", wr_err, 0);
    check_eq("ov_bursts", burst_cnt, 40);
    check_eq("ov_burst_err", burst_err, 0);
    check_eq("ov_max_addr", max_addr, 639);
    check_eq("ov_sticky", overrun, 1);

    // Reset in the middle of a burst, then a clean fetch
    start_line(16'd2, 1'b0, 1'b0, "mr");
    wait_wr(5, "mr", 500);
    sys_rst = 1'b1;
    @(negedge clk); #1;
    check_eq("mr_mem_req", mem_req, 0);
    check_eq("mr_buf_we", buf_we, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_overrun", overrun, 0);
    check_eq("mr_buf_addr", buf_addr, 0);
    check_eq("mr_cpu_rdata", cpu_rdata, 0);
    check_eq("mr_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    #1;
    sys_rst = 1'b0;
    start_line(16'd11, 1'b1, 1'b1, "pr");
    wait_idle("pr", 8000);
    check_eq("pr_writes", wr_cnt, 1024);
    check_eq("pr_wr_err", wr_err, 0);
    check_eq("pr_bursts", burst_cnt, 64);
    check_eq("pr_burst_err", burst_err, 0);
    check_eq("pr_overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch_arbiter.md
Name: vga_line_fetch_arbiter

Overview:
- Sits between the VGA line-buffer driver and the shared SDRAM controller port.
- On each new-line request it fetches one display line from SDRAM in bursts and writes it into line buffer A or B.
- Between VGA bursts it grants the SDRAM port to a single CPU requester, so neither side starves.
- VGA has priority. Overrun is flagged when a line cannot finish before the next request.

Parameters:
- BURST_LEN, 16: words per VGA read burst; must be a power of 2 and divide both line lengths.
- MEM_AW, 26: SDRAM word-address width.
- LINE_SHIFT, 10: log2 of the line stride in words. Line address = {line_addr, LINE_SHIFT zeros}.

Ports:
- sys_clk in 1: single clock; all logic is posedge.
- sys_rst in 1: synchronous, active-high reset.
- vga_mode in 1: 0 = 640 words per line, 1 = 1024 words per line; sampled at request edge.
- line_req in 1: level from the VGA driver, already synchronous to sys_clk; a rising edge starts a fetch.
- line_ab in 1: target buffer, 0 = A, 1 = B; sampled at request edge.
- line_addr in 16: line number; sampled at request edge.
- buf_we out 1: line-buffer write strobe.
- buf_sel out 1: 0 = A, 1 = B.
- buf_addr out 10: pixel index in the line.
- buf_wdata out 16: pixel data.
- mem_req out 1: held high until accepted.
- mem_ack in 1: accept strobe; the transaction starts when mem_req && mem_ack.
- mem_we out 1: 1 = single write, 0 = read.
- mem_burst out 1: 1 = read BURST_LEN words, 0 = single word.
- mem_addr out MEM_AW: word address.
- mem_wdata out 16: write data.
- mem_rdata in 16: read data.
- mem_rvalid in 1: one pulse per returned read word.
- cpu_req in 1: level, held until cpu_ack.
- cpu_we in 1: CPU write enable.
- cpu_addr in MEM_AW: CPU word address.
- cpu_wdata in 16: CPU write data.
- cpu_rdata out 16: CPU read data.
- cpu_ack out 1: one-cycle completion pulse.
- busy out 1: high while a line fetch is pending or active.
- overrun out 1: sticky error flag; cleared only by reset.

Behaviour:
- Reset values: mem_req, mem_we, mem_burst, buf_we, cpu_ack, busy, overrun = 0. mem_addr, buf_addr, buf_sel, cpu_rdata = 0. State = IDLE. Edge detector history = 0.
- Edge detect: a request edge occurs when line_req = 1 and its registered copy = 0. On the edge, latch:
  - base = line_addr << LINE_SHIFT (truncated to MEM_AW bits);
  - sel = line_ab;
  - nwords = 640 or 1024 per vga_mode;
  - word counter = 0;
  - set pending and busy.
- Edge while pending or while fetching:
  - set overrun = 1;
  - relatch all fields and restart at word 0;
  - an in-flight burst still completes on the mem port, but its data is written at the new sel/addr positions starting from 0.
- States:
  - IDLE: if pending, go to VGA_REQ. Else if cpu_req, go to CPU_REQ.
  - VGA_REQ: mem_req = 1, mem_we = 0, mem_burst = 1, mem_addr = base + word counter. On mem_ack, drop mem_req next cycle and go to VGA_DATA.
  - VGA_DATA: each mem_rvalid gives buf_we = 1, buf_wdata = mem_rdata, buf_sel = sel, buf_addr = word counter[9:0], then word counter + 1. This is registered, one cycle after rvalid.
  - After BURST_LEN rvalids:
    - if word counter == nwords: clear pending and busy, go to IDLE;
    - else if cpu_req: go to CPU_REQ (one CPU slot per VGA burst);
    - else go to VGA_REQ.
  - CPU_REQ: mem_req = 1, mem_burst = 0, mem_we = cpu_we, mem_addr = cpu_addr, mem_wdata = cpu_wdata.
    - Write: on mem_ack, pulse cpu_ack the next cycle and go to IDLE.
    - Read: on mem_ack, go to CPU_DATA.
  - CPU_DATA: on mem_rvalid, cpu_rdata = mem_rdata and cpu_ack pulses the next cycle; go to IDLE.
- Arbitration: in IDLE, VGA pending always wins. A CPU request waits at most one VGA burst plus its own access.
- mem_req is never asserted while a transaction is outstanding; there is only one transaction in flight.
- cpu_ack is one cycle. The CPU must drop cpu_req in the ack cycle, or a new access starts.
- mem_addr arithmetic is MEM_AW bits wide and wraps modulo 2^MEM_AW. buf_addr never exceeds 1023.
- Total line latency: nwords/BURST_LEN bursts plus CPU slots; a 1024-word line = 64 bursts.

Test Plan:
- Reset, then line_req rise with line_addr = 3, line_ab = 1, vga_mode = 0, a memory model with 2-cycle ack and 3-cycle first rvalid -> 40 bursts at mem_addr 0xC00, 0xC10, … 0xE70; 640 buf_we with sel = 1, buf_addr 0..639, data = model(address); busy falls after the last write; overrun stays 0.
- vga_mode = 1, line_addr = 0xFFFF (MEM_AW = 26) -> base 0x3FFFC00; 64 bursts; buf_addr reaches 1023; no address overflow beyond 26 bits.
- cpu_req write (addr 0x100, data 0xBEEF) held during a VGA fetch -> served after the current burst only; exactly one cpu_ack; the VGA fetch resumes at the next burst address; model holds 0xBEEF.
- CPU read of 0x100 while idle -> cpu_rdata = 0xBEEF with a single cpu_ack; mem_burst = 0.
- Second line_req edge (line_addr = 7) issued mid-fetch -> overrun = 1 and stays 1; the fetch restarts at 0x1C00, buf_addr restarts at 0; exactly nwords writes after the restart.
- sys_rst asserted mid-burst -> next cycle all outputs at reset values; the next line_req edge starts cleanly from word 0.
